// File: rtl/async_memory.sv
// async_memory: byte-wide RAM with a clocked write port, a combinational read
// port and a hardware clear sweep that runs after every synchronous reset.
module async_memory #(
    parameter int unsigned asz   = 16,
    parameter int unsigned depth = 8192,
    parameter int unsigned dsz   = 8
) (
    input  logic           wr_clk,
    input  logic           reset,
    input  logic [asz-1:0] addr,
    input  logic [dsz-1:0] wr_data,
    input  logic           wr_cs,
    input  logic           rd_cs,
    output logic [dsz-1:0] rd_data,
    output logic           ready
);

    localparam int unsigned aw       = $clog2(depth);
    localparam logic [aw-1:0] last_idx = aw'(depth - 1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [aw-1:0]  ptr;
    logic [aw-1:0]  ptr_next;

    logic           mem_we;
    logic [aw-1:0]  mem_idx;
    logic [dsz-1:0] mem_wdata;
    logic [dsz-1:0] mem [depth];

    logic [aw-1:0]  idx;
    logic           unused_addr;

    // Upper address bits alias onto the low aw bits and are otherwise ignored.
    assign idx         = addr[aw-1:0];
    assign unused_addr = ^addr;

    // The array is usable only once the sweep has left the clear state.
    assign ready = (state == ST_READY);

    // State and clear pointer; reset restarts the sweep from index 0.
    always_ff @(posedge wr_clk) begin
        if (reset) begin
            state <= ST_CLEAR;
            ptr   <= '0;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
        end
    end

    // Next state and write-port steering: sweep zeros while clearing, user writes once ready.
    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        mem_we     = 1'b0;
        mem_idx    = idx;
        mem_wdata  = wr_data;
        if (!reset) begin
            unique case (state)
                ST_CLEAR: begin
                    mem_we    = 1'b1;
                    mem_idx   = ptr;
                    mem_wdata = '0;
                    ptr_next  = ptr + aw'(1);
                    if (ptr == last_idx) begin
                        state_next = ST_READY;
                    end
                end
                ST_READY: begin
                    mem_we = wr_cs;
                end
            endcase
        end
    end

    // Single write port into the storage array; reset itself never writes.
    always_ff @(posedge wr_clk) begin
        if (mem_we) begin
            mem[mem_idx] <= mem_wdata;
        end
    end

    // Combinational read: open bus when deselected, zeros until the clear completes.
    always_comb begin
        rd_data = '1;
        if (rd_cs) begin
            rd_data = ready ? mem[idx] : '0;
        end
    end

endmodule

// File: tb/tb_async_memory.sv
// Scoreboard bench for async_memory: stimulus queues expected (rd_data, ready)
// pairs, a negedge monitor pops and compares them.
module tb_async_memory;

    logic        clk;
    logic        reset;
    logic [15:0] addr;
    logic [7:0]  wr_data;
    logic        wr_cs;
    logic        rd_cs;
    logic [7:0]  rd_data;
    logic        ready;

    int n_chk;
    int n_fail;

    typedef struct {
        string      name;
        logic [7:0] data;
        logic       rdy;
    } exp_t;

    exp_t sb[$];
    exp_t cur;

    async_memory #(
        .asz  (16),
        .depth(8192),
        .dsz  (8)
    ) dut (
        .wr_clk (clk),
        .reset  (reset),
        .addr   (addr),
        .wr_data(wr_data),
        .wr_cs  (wr_cs),
        .rd_cs  (rd_cs),
        .rd_data(rd_data),
        .ready  (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: compare the pending expectation midway between active edges.
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            cur = sb.pop_front();
            n_chk++;
            if (rd_data !== cur.data) begin
                n_fail++;
                $display("FAIL %s rd_data: got %02h expected %02h at %0t", cur.name, rd_data, cur.data, $time);
            end
            n_chk++;
            if (ready !== cur.rdy) begin
                n_fail++;
                $display("FAIL %s ready: got %0b expected %0b at %0t", cur.name, ready, cur.rdy, $time);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] a, input logic rc, input logic wc,
                         input logic [7:0] wd, input logic rs);
        addr    = a;
        rd_cs   = rc;
        wr_cs   = wc;
        wr_data = wd;
        reset   = rs;
    endtask

    task automatic expect_out(input string nm, input logic [7:0] d, input logic r);
        exp_t e;
        e.name = nm;
        e.data = d;
        e.rdy  = r;
        sb.push_back(e);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;

        // Two reset edges, then release.
        drive(16'h0000, 1'b0, 1'b0, 8'h00, 1'b1);
        step();
        expect_out("reset_open_bus", 8'hFF, 1'b0);
        step();
        reset = 1'b0;

        // First sweep: ready stays low for 8191 edges; a write at 0x0010 mid-sweep is ignored.
        for (int i = 0; i < 8192; i++) begin
            drive((i == 8099) ? 16'h0010 : 16'h0000, (i == 0), (i == 8099), 8'h77, 1'b0);
            expect_out("sweep1", (i == 0) ? 8'h00 : 8'hFF, 1'b0);
            step();
        end
        drive(16'h0000, 1'b1, 1'b0, 8'h00, 1'b0);
        expect_out("ready_rd_0000", 8'h00, 1'b1);
        step();
        drive(16'h1FFF, 1'b1, 1'b0, 8'h00, 1'b0);
        expect_out("ready_rd_1fff", 8'h00, 1'b1);
        step();
        drive(16'h0010, 1'b1, 1'b0, 8'h00, 1'b0);
        expect_out("sweep_wr_ignored", 8'h00, 1'b1);
        step();

        // Write and aliased reads.
        drive(16'hC123, 1'b0, 1'b1, 8'hA5, 1'b0);
        expect_out("wr_open_bus", 8'hFF, 1'b1);
        step();
        drive(16'hC123, 1'b1, 1'b0, 8'h00, 1'b0);
        expect_out("rd_c123", 8'hA5, 1'b1);
        step();
        drive(16'h0123, 1'b1, 1'b0, 8'h00, 1'b0);
        expect_out("rd_alias_0123", 8'hA5, 1'b1);
        step();
        drive(16'h0123, 1'b0, 1'b0, 8'h00, 1'b0);
        expect_out("rd_cs_low", 8'hFF, 1'b1);
        step();
        drive(16'h0123, 1'b1, 1'b0, 8'h00, 1'b0);
        expect_out("rd_cs_raise", 8'hA5, 1'b1);
        step();

        // Simultaneous read/write at one address: old data before the edge, new after.
        drive(16'h0040, 1'b1, 1'b1, 8'h11, 1'b0);
        expect_out("rw_pre_11", 8'h00, 1'b1);
        step();
        drive(16'h0040, 1'b1, 1'b1, 8'h22, 1'b0);
        expect_out("rw_old_11", 8'h11, 1'b1);
        step();
        drive(16'h0040, 1'b1, 1'b0, 8'h00, 1'b0);
        expect_out("rw_new_22", 8'h22, 1'b1);
        step();

        // Reset while ready, with a coincident write request.
        drive(16'h0200, 1'b1, 1'b1, 8'h5A, 1'b0);
        expect_out("wr_0200_pre", 8'h00, 1'b1);
        step();
        drive(16'h0200, 1'b1, 1'b0, 8'h00, 1'b0);
        expect_out("rd_0200", 8'h5A, 1'b1);
        step();
        drive(16'h0300, 1'b1, 1'b1, 8'h99, 1'b1);
        expect_out("reset_edge_pre", 8'h00, 1'b1);
        step();

        // Second sweep, interrupted by a one-cycle reset at edge 4000.
        for (int i = 0; i < 4000; i++) begin
            drive(16'h0200, 1'b0, 1'b0, 8'h00, (i == 3999));
            expect_out((i == 0) ? "reset_drops_ready" : "sweep2a", 8'hFF, 1'b0);
            step();
        end
        for (int i = 0; i < 8192; i++) begin
            drive(16'h0200, (i == 0), 1'b0, 8'h00, 1'b0);
            expect_out("sweep2b", (i == 0) ? 8'h00 : 8'hFF, 1'b0);
            step();
        end
        drive(16'h0200, 1'b1, 1'b0, 8'h00, 1'b0);
        expect_out("cleared_0200", 8'h00, 1'b1);
        step();
        drive(16'h0300, 1'b1, 1'b0, 8'h00, 1'b0);
        expect_out("cleared_0300", 8'h00, 1'b1);
        step();
        drive(16'hC123, 1'b1, 1'b0, 8'h00, 1'b0);
        expect_out("cleared_c123", 8'h00, 1'b1);
        step();
        drive(16'h0040, 1'b1, 1'b0, 8'h00, 1'b0);
        expect_out("cleared_0040", 8'h00, 1'b1);
        step();

        // Top index through an aliased address.
        drive(16'h1FFF, 1'b0, 1'b1, 8'h3C, 1'b0);
        expect_out("wr_1fff", 8'hFF, 1'b1);
        step();
        drive(16'hFFFF, 1'b1, 1'b0, 8'h00, 1'b0);
        expect_out("rd_alias_ffff", 8'h3C, 1'b1);
        step();
        drive(16'h0000, 1'b0, 1'b0, 8'h00, 1'b0);
        step();

        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/async_memory.md
# async_memory

Byte-wide RAM with a synchronous write port and a combinational (asynchronous) read port, used for both Game Boy work RAM and video RAM (8 KiB each) beside the `gameboy` core. Writes land on the rising clock edge when the write strobe is active. Reads return data in the same cycle the address is presented. A synchronous reset runs a hardware clear of the whole array.

## Interface

Parameters:
- `asz`, default 16: width of the `addr` port in bits.
- `depth`, default 8192: number of words. Must be a power of two and ≤ 2^asz. `aw = $clog2(depth)`.
- `dsz`, default 8: data width in bits.

Ports:
- `wr_clk`, input, 1: the single clock. All state changes occur on its rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `addr`, input, asz: shared read/write address. Only `addr[aw-1:0]` is used; upper bits are ignored, so addresses alias.
- `wr_data`, input, dsz: write data.
- `wr_cs`, input, 1: write enable, active high.
- `rd_cs`, input, 1: read enable, active high.
- `rd_data`, output, dsz: combinational read data.
- `ready`, output, 1: high when the clear sweep is finished and the RAM accepts accesses.

## Operation

- Storage is `depth` words of `dsz` bits. Index = `addr[aw-1:0]`.
- **Reset:**
  - Any cycle with `reset=1` sets the clear pointer to 0 and `ready` to 0.
  - Reset does not touch the array in that same cycle.
- **Clear sweep (`ready=0`, `reset=0`):**
  - Each rising edge writes 0 to `mem[ptr]` and increments `ptr`.
  - When the edge clears index `depth-1`, `ready` is 1 after that edge.
  - The sweep takes exactly `depth` cycles after reset deasserts.
  - `wr_cs` is ignored throughout the sweep.
- **Write (`ready=1`):** on a rising edge with `wr_cs=1`, `mem[addr[aw-1:0]] <= wr_data`.
- **Read (combinational):**
  - `ready=1` and `rd_cs=1`: `rd_data = mem[addr[aw-1:0]]`.
  - `rd_cs=0`: `rd_data = {dsz{1'b1}}` (open bus, 0xFF).
  - `ready=0` and `rd_cs=1`: `rd_data = 0`.
- **Simultaneous `rd_cs` and `wr_cs` at the same address:**
  - `rd_data` shows the old contents until the edge and the new value after it.
  - There is no write-through bypass.
- The power-up contents before the first reset are undefined. The bench must reset first.

## Timing

- Write latency: 1 edge. The data is readable combinationally immediately after the edge.
- Read latency: 0 cycles, purely combinational from `addr`, `rd_cs` and `ready`.
- Reset values:
  - `ready = 0`.
  - `rd_data` follows the read rule, so it is 0xFF with `rd_cs=0` and 0x00 with `rd_cs=1`.
- Clear duration: `ready` rises `depth` rising edges after the first edge with `reset=0`.
  - For `depth=8192`: the 8192nd edge.
- Reset asserted mid-sweep restarts the pointer at 0. The full `depth` cycles are required again.
- Reset asserted while `ready=1`:
  - Drops `ready` on that edge.
  - The write is suppressed even if `wr_cs=1` that cycle, because reset has priority.
  - A new sweep clears all contents.
- Pointer width is `aw`. `ready` is latched before the pointer wraps; the wrap to 0 is unused.

## Test plan

1. Assert `reset` for 2 cycles, then release. Confirm:
   - `ready=0` for 8191 edges and `ready=1` after edge 8192.
   - Reading addr 0x0000 and addr 0x1FFF with `rd_cs=1` returns 0x00.
2. After `ready`, write 0xA5 to 0xC123 with `wr_cs=1` for one edge, then `rd_cs=1` at 0xC123. Confirm:
   - `rd_data` is 0xA5.
   - Reading 0x0123 also returns 0xA5 (aliasing through low 13 bits).
3. With `rd_cs=0` at any address, confirm `rd_data`=0xFF. Raising `rd_cs` in the same cycle shows the stored byte with zero latency.
4. With `rd_cs=1` and `wr_cs=1` at 0x0040 holding 0x11, drive `wr_data`=0x22:
   - Before the edge, `rd_data`=0x11.
   - After the edge, `rd_data`=0x22.
5. Write 0x77 during the clear sweep (`ready=0`). After `ready`, the location reads 0x00.
6. Mid-sweep, at edge 4000, assert `reset` for 1 cycle. Confirm `ready` rises exactly 8192 edges after the release, not earlier.
